// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response handshakes and data-memory port of the MEM-stage load/store unit.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_wd;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_wreg;
    logic [4:0]  resp_wd;
    logic [31:0] resp_wdata;
    logic        resp_excp;
    logic        stall_req;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_wd, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_wreg, resp_wd, resp_wdata, resp_excp, stall_req,
        output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata
    );
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_wd, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_wreg, resp_wd, resp_wdata, resp_excp, stall_req,
        input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: one-at-a-time load/store unit driving a big-endian byte-lane data memory for one cycle.
module mem_lsu #(
    parameter bit EXCP_MISALIGN = 1'b1
) (
    input logic      clk,
    input logic      rst,
    mem_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [4:0]  wd_q;
    logic        wreg_q, excp_q;
    // 0 byte, 1 halfword, 2 word
    function automatic logic [1:0] op_size(input logic [2:0] o);
        return (o == 3'd4 || o == 3'd7) ? 2'd2 : (o == 3'd2 || o == 3'd3 || o == 3'd6) ? 2'd1 : 2'd0;
    endfunction
    logic [1:0] sz_in, a_in, sz, a;
    logic       mis_in, accept, store;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld;
    assign sz_in  = op_size(bus.req_op);
    assign a_in   = bus.req_addr[1:0];
    assign mis_in = (sz_in == 2'd1 && a_in[0]) || (sz_in == 2'd2 && a_in != 2'd0);
    assign accept = state == IDLE && bus.req_valid;
    assign sz     = op_size(op_q);
    assign a      = addr_q[1:0];
    assign store  = op_q >= 3'd5;
    assign lb     = 8'(bus.mem_rdata >> (5'd24 - {a, 3'b000}));
    assign lh     = a[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
    assign ld     = sz == 2'd0 ? {{24{~op_q[0] & lb[7]}}, lb} :
                    sz == 2'd1 ? {{16{~op_q[0] & lh[15]}}, lh} : bus.mem_rdata;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.req_valid ? ((mis_in && EXCP_MISALIGN) ? RESP : ACCESS) : IDLE;
            ACCESS:  state_nx = RESP;
            default: state_nx = bus.resp_ready ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            excp_q  <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            op_q    <= bus.req_op;
            addr_q  <= {bus.req_addr[31:2], sz_in == 2'd2 ? 2'b00 : sz_in == 2'd1 ? {a_in[1], 1'b0} : a_in};
            wdata_q <= bus.req_wdata;
            wd_q    <= bus.req_wd;
            wreg_q  <= 1'b0;
            excp_q  <= mis_in && EXCP_MISALIGN;
            rdata_q <= '0;
        end else if (state == ACCESS) begin
            wreg_q  <= ~store;
            rdata_q <= store ? 32'd0 : ld;
        end
    end
    always_comb begin
        bus.req_ready  = state == IDLE;
        bus.stall_req  = state != IDLE;
        bus.resp_valid = state == RESP;
        bus.resp_wreg  = state == RESP && wreg_q;
        bus.resp_excp  = state == RESP && excp_q;
        bus.resp_wd    = wd_q;
        bus.resp_wdata = rdata_q;
        bus.mem_ce     = state == ACCESS;
        bus.mem_we     = state == ACCESS && store;
        bus.mem_addr   = bus.mem_ce ? addr_q : 32'd0;
        bus.mem_sel    = !bus.mem_ce ? 4'b0000 : sz == 2'd0 ? 4'b1000 >> a : sz == 2'd1 ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        bus.mem_wdata  = !bus.mem_we ? 32'd0 : sz == 2'd0 ? {4{wdata_q[7:0]}} : sz == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage. It sits directly upstream of the byte-lane data memory (`dm`) and feeds it.

- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the memory's `ce`/`we`/`addr`/`sel`/`data_i` for exactly one cycle.
- Byte-replicates store data and extracts plus sign/zero-extends load data.
- Returns a write-back response, or a misalignment exception, over a second handshake.
- Raises `stall_req` to the pipeline controller while busy.

## Interface
Parameters:
- `EXCP_MISALIGN`, default 1: 1 means a misaligned halfword/word access raises `resp_excp` and makes no memory access. 0 means `addr[1:0]` (or `addr[0]` for halfwords) is forced to zero and the access proceeds.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; equals (state == IDLE).
- `req_op` in 3: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; bits used are [7:0] for SB, [15:0] for SH, all for SW.
- `req_wd` in 5: destination register for loads.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts response.
- `resp_wreg` out 1: 1 for a completed load, 0 for a store or exception.
- `resp_wd` out 5: destination register, copied from the request.
- `resp_wdata` out 32: extended load data; 0 for stores and exceptions.
- `resp_excp` out 1: misaligned access.
- `stall_req` out 1: high whenever state != IDLE.
- `mem_ce` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_sel` out 4, `mem_wdata` out 32: to the memory.
- `mem_rdata` in 32: combinational read data from the memory.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On `req_valid` && `req_ready`, latch op, addr, wdata and wd.
  - Go to RESP with `excp` set if misaligned and `EXCP_MISALIGN` = 1; otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - `mem_ce` = 1; `mem_we` = 1 for stores; `mem_addr` = latched addr; `mem_sel` and `mem_wdata` as below.
  - For loads, capture the extended `mem_rdata` into the response register at the closing edge.
  - Go to RESP.
- RESP:
  - `resp_valid` = 1; hold all `resp_*` stable until `resp_valid` && `resp_ready`, then go to IDLE.
  - No new request is accepted in the same cycle as the response is accepted.
- Lane mapping is big-endian, with `a` = `addr[1:0]`:
  - Byte access: `mem_sel` = 4'b1000 >> `a`.
  - Halfword access: `mem_sel` = 4'b1100 for a=0, 4'b0011 for a=2.
  - Word access: `mem_sel` = 4'b1111.
- Store data is replicated across lanes: SB drives {4{wdata[7:0]}}, SH drives {2{wdata[15:0]}}, SW drives wdata.
- Load extraction:
  - Byte lane `a` is `rdata[31-8a -: 8]`; halfword at a=0 is [31:16], at a=2 is [15:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Misalignment means halfword with `a[0]`=1, or word with `a` != 0. Byte accesses are never misaligned.
- Outside ACCESS, all `mem_*` outputs are 0, which leaves the memory chip-disabled.

## Timing
- Reset values: state IDLE; `req_ready` = 1; `resp_valid`, `resp_wreg`, `resp_excp`, `stall_req` and all `mem_*` = 0; `resp_wd` = 0; `resp_wdata` = 0.
- Request accepted at edge T:
  - ACCESS occupies cycle T..T+1; a store commits in the memory at edge T+1.
  - `resp_valid` rises after edge T+1. Minimum latency is 2 cycles; throughput is one request per 3 cycles.
- Misaligned request accepted at edge T: `resp_valid` rises after edge T, with no memory cycle at all.
- `resp_ready` held low keeps RESP indefinitely, with outputs frozen and `stall_req` = 1.
- Reset asserted mid-ACCESS clears `mem_ce` immediately (asynchronously), so no store commits. Reset asserted in RESP drops the pending response.
- `req_valid` while not ready: ignored, and the request is not latched.

## Test plan
- SW addr 0x10 data 0xA1B2C3D4, then LW 0x10 -> store asserts `mem_sel` 4'b1111 for one cycle; LW response has `resp_wdata` 0xA1B2C3D4, `resp_wreg` 1, at latency 2.
- SB addr 0x21 data 0x80, then LB 0x21 and LBU 0x21 -> store `mem_sel` 4'b0100, `mem_wdata` 0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH addr 0x32 data 0x8001, then LH 0x32 and LHU 0x30 with word 0x12348001 -> store `mem_sel` 4'b0011; LH returns 0xFFFF8001, LHU returns 0x00001234.
- LW addr 0x13 with `EXCP_MISALIGN`=1 -> `mem_ce` never asserts; `resp_excp` 1, `resp_wreg` 0, `resp_valid` one cycle after acceptance.
- Hold `resp_ready` low for 5 cycles after a load -> `resp_*` stable; `req_ready` 0; a `req_valid` pulse during this time is ignored; the next request is accepted only after the response is handed off.
- Assert `rst` during the ACCESS of SW 0x40 -> all `mem_*` are 0 immediately; a later LW 0x40 returns the pre-store value.
